serial_adder_6bit: RTL and testbench

- Bit-serial ripple-carry adder: the addition counterpart to the team's 6-bit ripple-borrow subtractor in the ALU datapath.
- Latches two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Resolves one bit per clock through a single full-adder cell and a registered carry.
- Presents sum, carry-out and signed overflow through a second valid/ready handshake.
- Trades latency for area in the ALU add path.

---
 rtl/serial_adder_6bit.sv | 93 +++++++++
 tb/tb_serial_adder_6bit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_6bit.sv
// Bit-serial ripple-carry adder: one full-adder cell, one bit per clock,
// valid/ready handshakes on the operand and result sides.
module serial_adder_6bit #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nstate;
    logic [WIDTH-1:0] a_sh, b_sh, ps;
    logic             c;
    logic             c_msb_in;
    logic [CNT_W-1:0] cnt;
    logic             sbit, cnext, last;

    assign sbit  = a_sh[0] ^ b_sh[0] ^ c;
    assign cnext = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
    assign last  = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (in_valid)  nstate = RUN;
            RUN:     if (last)      nstate = DONE;
            DONE:    if (out_ready) nstate = IDLE;
            default:                nstate = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            ps       <= '0;
            c        <= 1'b0;
            c_msb_in <= 1'b0;
            cnt      <= '0;
            S        <= '0;
            Cout     <= 1'b0;
            Ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh <= A;
                    b_sh <= B;
                    c    <= Cin;
                    ps   <= '0;
                    cnt  <= '0;
                end
                RUN: begin
                    ps   <= {sbit, ps[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= cnext;
                    cnt  <= cnt + CNT_W'(1);
                    // carry out of bit WIDTH-2 is the carry into the MSB
                    if (cnt == CNT_W'(WIDTH - 2)) c_msb_in <= cnext;
                    if (last) begin
                        S    <= {sbit, ps[WIDTH-1:1]};
                        Cout <= cnext;
                        Ovf  <= c_msb_in ^ cnext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_6bit.sv
// Self-checking bench for serial_adder_6bit: directed vectors, stall/ignore,
// async reset mid-run, and all 2**13 operand combinations in random order.
module tb_serial_adder_6bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [5:0] A, B, S;
    logic       Cin, Cout, Ovf;

    int tests = 0;
    int fails = 0;

    serial_adder_6bit #(.WIDTH(6), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [7:0] ref_add(input logic [5:0] a, b, input logic ci);
        int u, sa, sb, ss;
        logic [7:0] r;
        u  = int'(a) + int'(b) + int'(ci);
        sa = (a >= 6'd32) ? int'(a) - 64 : int'(a);
        sb = (b >= 6'd32) ? int'(b) - 64 : int'(b);
        ss = sa + sb + int'(ci);
        r[5:0] = u[5:0];
        r[6]   = (u >= 64);
        r[7]   = (ss > 31) || (ss < -32);
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [5:0] a, b, input logic ci,
                          output logic [5:0] s, output logic co, ov, output int lat);
        in_valid = 1'b1; A = a; B = b; Cin = ci;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        s = S; co = Cout; ov = Ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, S, Cout, Ovf} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_held: rdy=%b vld=%b S=%0d C=%b V=%b, need rdy=1 vld=0 S=0 C=0 V=0",
                     in_ready, out_valid, S, Cout, Ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL reset_released: rdy=%b vld=%b, need rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [5:0] va[5] = '{6'd13, 6'h3F, 6'h20, 6'd0, 6'h3F};
        logic [5:0] vb[5] = '{6'd22, 6'h01, 6'h20, 6'd0, 6'h3F};
        logic       vc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] ex[5] = '{{1'b1, 1'b0, 6'd35}, {1'b0, 1'b1, 6'd0}, {1'b1, 1'b1, 6'd0},
                              {1'b0, 1'b0, 6'd1}, {1'b0, 1'b1, 6'h3F}};
        logic [5:0] s;
        logic       co, ov;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], s, co, ov, lat);
            tests++;
            if ({ov, co, s} !== ex[i] || lat != 6) begin
                fails++;
                $display("FAIL directed_%0d: S=%0d C=%b V=%b lat=%0d, need S=%0d C=%b V=%b lat=6",
                         i, s, co, ov, lat, ex[i][5:0], ex[i][6], ex[i][7]);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        in_valid = 1'b1; A = 6'd5; B = 6'd9; Cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
        tests++;
        if (!out_valid || S !== 6'd14 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            fails++;
            $display("FAIL hold_first: vld=%b S=%0d C=%b V=%b, need vld=1 S=14 C=0 V=0",
                     out_valid, S, Cout, Ovf);
        end
        in_valid = 1'b1; A = 6'd7; B = 6'd8; Cin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, S, Cout, Ovf} !== {1'b1, 1'b0, 6'd14, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL hold_stall_%0d: vld=%b rdy=%b S=%0d C=%b V=%b, need vld=1 rdy=0 S=14 C=0 V=0",
                         i, out_valid, in_ready, S, Cout, Ovf);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL hold_release: vld=%b rdy=%b, need vld=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_accept_next: rdy=%b, need rdy=0", in_ready);
        end
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
        tests++;
        if (!out_valid || lat != 6 || S !== 6'd16 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            fails++;
            $display("FAIL hold_second: vld=%b lat=%0d S=%0d C=%b V=%b, need vld=1 lat=6 S=16 C=0 V=0",
                     out_valid, lat, S, Cout, Ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [5:0] s;
        logic       co, ov, seen;
        int         lat;
        in_valid = 1'b1; A = 6'h2A; B = 6'h1B; Cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({in_ready, out_valid, S, Cout, Ovf} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rst_mid_run: rdy=%b vld=%b S=%0d C=%b V=%b, need rdy=1 vld=0 S=0 C=0 V=0",
                     in_ready, out_valid, S, Cout, Ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= out_valid; end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_pulse: out_valid seen=%b, need 0", seen);
        end
        run_op(6'd30, 6'd31, 1'b1, s, co, ov, lat);
        tests++;
        if ({ov, co, s} !== ref_add(6'd30, 6'd31, 1'b1) || lat != 6) begin
            fails++;
            $display("FAIL rst_after_op: S=%0d C=%b V=%b lat=%0d, need S=62 C=0 V=1 lat=6",
                     s, co, ov, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] order[8192];
        logic [12:0] tmp, v;
        logic [5:0]  s;
        logic        co, ov;
        logic [7:0]  ex;
        int          lat, j;
        for (int i = 0; i < 8192; i++) order[i] = 13'(i);
        for (int i = 8191; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 8192; i++) begin
            v  = order[i];
            ex = ref_add(v[12:7], v[6:1], v[0]);
            run_op(v[12:7], v[6:1], v[0], s, co, ov, lat);
            tests++;
            if ({ov, co, s} !== ex || lat != 6) begin
                fails++;
                $display("FAIL b2b A=%0d B=%0d Cin=%b: S=%0d C=%b V=%b lat=%0d, need S=%0d C=%b V=%b lat=6",
                         v[12:7], v[6:1], v[0], s, co, ov, lat, ex[5:0], ex[6], ex[7]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
